// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: writeback (A) always wins; multi-cycle unit (B)
// writes are buffered in a small FIFO and drained into idle write-port cycles.
module regfile_write_arbiter #(
   parameter int unsigned DEPTH        = 2,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wb_we,
   input  logic [4:0]  wb_addr,
   input  logic [31:0] wb_data,
   input  logic        mc_valid,
   input  logic [4:0]  mc_addr,
   input  logic [31:0] mc_data,
   output logic        mc_ready,
   output logic        rf_we,
   output logic [4:0]  rf_addr,
   output logic [31:0] rf_data,
   output logic [31:0] pend_mask,
   output logic        stall_req
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef logic [AW-1:0] ptr_t;
   typedef logic [AW:0]   cnt_t;

   logic [4:0]  addr_q [DEPTH];
   logic [31:0] data_q [DEPTH];

   ptr_t       rd_ptr_q, rd_ptr_d;
   ptr_t       wr_ptr_q, wr_ptr_d;
   cnt_t       count_q, count_d;
   logic [3:0] starve_q, starve_d;
   logic       stall_q, stall_d;

   logic a_act;
   logic push;
   logic store;
   logic pop;
   ptr_t idx;

   assign a_act     = wb_we && (wb_addr != 5'd0);
   assign mc_ready  = !rst && (count_q < cnt_t'(DEPTH));
   assign push      = mc_valid && mc_ready;
   assign store     = push && (mc_addr != 5'd0);
   assign stall_req = stall_q;

   always_comb begin
      rf_we   = 1'b0;
      rf_addr = '0;
      rf_data = '0;
      pop     = 1'b0;
      if (a_act) begin
         rf_we   = 1'b1;
         rf_addr = wb_addr;
         rf_data = wb_data;
      end else if (count_q != '0) begin
         rf_we   = 1'b1;
         rf_addr = addr_q[rd_ptr_q];
         rf_data = data_q[rd_ptr_q];
         pop     = 1'b1;
      end
   end

   // Entry i (counted from the head) is live when i < count.
   always_comb begin
      pend_mask = '0;
      idx       = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         idx = rd_ptr_q + ptr_t'(i);
         if (cnt_t'(i) < count_q) begin
            pend_mask[addr_q[idx]] = 1'b1;
         end
      end
   end

   always_comb begin
      rd_ptr_d = rd_ptr_q + ptr_t'(pop);
      wr_ptr_d = wr_ptr_q + ptr_t'(store);
      count_d  = count_q;
      if (store && !pop) begin
         count_d = count_q + cnt_t'(1);
      end else if (!store && pop) begin
         count_d = count_q - cnt_t'(1);
      end

      starve_d = starve_q;
      if (pop || (count_q == '0)) begin
         starve_d = '0;
      end else if (a_act && (starve_q != 4'hF)) begin
         starve_d = starve_q + 4'd1;
      end
      stall_d = (starve_d >= 4'(STARVE_LIMIT));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         starve_q <= '0;
         stall_q  <= 1'b0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         starve_q <= starve_d;
         stall_q  <= stall_d;
      end
   end

   always_ff @(posedge clk) begin
      if (store) begin
         addr_q[wr_ptr_q] <= mc_addr;
         data_q[wr_ptr_q] <= mc_data;
      end
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized and directed bench for regfile_write_arbiter against a queue-based
// reference model of the arbitration rules.
module tb_regfile_write_arbiter;

   localparam int unsigned DEPTH        = 2;
   localparam int unsigned STARVE_LIMIT = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_we;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        mc_valid;
   logic [4:0]  mc_addr;
   logic [31:0] mc_data;
   logic        mc_ready;
   logic        rf_we;
   logic [4:0]  rf_addr;
   logic [31:0] rf_data;
   logic [31:0] pend_mask;
   logic        stall_req;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   // Model state: pending B writes as {addr, data}, oldest first.
   logic [36:0] mq [$];
   int unsigned m_starve = 0;
   bit          m_stall  = 1'b0;

   regfile_write_arbiter #(
      .DEPTH        (DEPTH),
      .STARVE_LIMIT (STARVE_LIMIT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .wb_we     (wb_we),
      .wb_addr   (wb_addr),
      .wb_data   (wb_data),
      .mc_valid  (mc_valid),
      .mc_addr   (mc_addr),
      .mc_data   (mc_data),
      .mc_ready  (mc_ready),
      .rf_we     (rf_we),
      .rf_addr   (rf_addr),
      .rf_data   (rf_data),
      .pend_mask (pend_mask),
      .stall_req (stall_req)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs after the falling edge, check outputs, advance the model.
   task automatic cyc(input logic r, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic mv, input logic [4:0] ma, input logic [31:0] md);
      bit          a;
      bit          e_ready;
      bit          e_we;
      logic [4:0]  e_addr;
      logic [31:0] e_data;
      logic [31:0] e_pend;
      bit          do_pop;
      bit          do_push;
      @(negedge clk);
      rst = r; wb_we = we; wb_addr = wa; wb_data = wd;
      mc_valid = mv; mc_addr = ma; mc_data = md;
      #1;
      if (r) begin
         mq.delete();
         m_starve = 0;
         m_stall  = 1'b0;
      end
      a       = we && (wa != 5'd0);
      e_ready = !r && (mq.size() < DEPTH);
      e_we    = 1'b0;
      e_addr  = '0;
      e_data  = '0;
      if (a) begin
         e_we = 1'b1; e_addr = wa; e_data = wd;
      end else if (mq.size() > 0) begin
         e_we = 1'b1; e_addr = mq[0][36:32]; e_data = mq[0][31:0];
      end
      e_pend = '0;
      foreach (mq[i]) e_pend[mq[i][36:32]] = 1'b1;

      check("rf_we",     32'(rf_we),     32'(e_we));
      check("rf_addr",   32'(rf_addr),   32'(e_addr));
      check("rf_data",   rf_data,        e_data);
      check("mc_ready",  32'(mc_ready),  32'(e_ready));
      check("pend_mask", pend_mask,      e_pend);
      check("stall_req", 32'(stall_req), 32'(m_stall));

      if (!r) begin
         do_pop  = !a && (mq.size() > 0);
         do_push = mv && e_ready;
         if (do_pop || mq.size() == 0) m_starve = 0;
         else if (a && m_starve < 15) m_starve = m_starve + 1;
         m_stall = (m_starve >= STARVE_LIMIT);
         if (do_pop) void'(mq.pop_front());
         if (do_push && ma != 5'd0) mq.push_back({ma, md});
      end
   endtask

   task automatic idle(input int unsigned n);
      for (int unsigned k = 0; k < n; k++) cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
   endtask

   initial begin
      rst = 1'b1; wb_we = 1'b0; wb_addr = '0; wb_data = '0;
      mc_valid = 1'b0; mc_addr = '0; mc_data = '0;

      // Reset state, then release
      cyc(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      cyc(1'b1, 1'b1, 5'd4, 32'hA5A5A5A5, 1'b1, 5'd6, 32'h1);
      idle(2);

      // B alone
      cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF);
      idle(3);

      // Collision: A every cycle while B waits, then A drops
      cyc(1'b0, 1'b1, 5'd3, 32'h11, 1'b1, 5'd7, 32'h22);
      for (int unsigned k = 0; k < 6; k++) cyc(1'b0, 1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 32'd0);
      idle(3);

      // Full: mc_valid held while A blocks, then release A
      for (int unsigned k = 0; k < 4; k++)
         cyc(1'b0, 1'b1, 5'd2, 32'h100 + k, 1'b1, 5'd8 + 5'(k), 32'h200 + k);
      for (int unsigned k = 0; k < 3; k++)
         cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd20, 32'h300 + k);
      idle(4);

      // Register 0: A to r0 does not block a buffered B entry; B to r0 is dropped
      cyc(1'b0, 1'b1, 5'd3, 32'h33, 1'b1, 5'd12, 32'hCAFE);
      cyc(1'b0, 1'b1, 5'd0, 32'h44, 1'b0, 5'd0, 32'd0);
      cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hBAD0);
      idle(2);

      // Push and pop together across pointer wrap
      cyc(1'b0, 1'b1, 5'd9, 32'h55, 1'b1, 5'd1, 32'h1000);
      for (int unsigned k = 0; k < 6; k++)
         cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd13 + 5'(k), 32'h2000 + k);
      idle(3);

      // Reset mid-stream with two buffered entries and duplicate addresses
      cyc(1'b0, 1'b1, 5'd3, 32'h66, 1'b1, 5'd17, 32'h77);
      cyc(1'b0, 1'b1, 5'd3, 32'h66, 1'b1, 5'd17, 32'h78);
      cyc(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd18, 32'h79);
      cyc(1'b1, 1'b1, 5'd11, 32'h88, 1'b0, 5'd0, 32'd0);
      idle(4);

      // Randomized traffic
      for (int unsigned k = 0; k < 600; k++) begin
         logic       r;
         logic       we;
         logic       mv;
         logic [4:0] wa;
         logic [4:0] ma;
         r  = ($urandom_range(63) == 0);
         we = ($urandom_range(99) < 60);
         mv = ($urandom_range(99) < 50);
         wa = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom);
         ma = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(3));
         cyc(r, we, wa, $urandom, mv, ma, $urandom);
      end
      idle(4);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
